coeff_lut_stream: RTL and testbench
===================================

Name: coeff_lut_stream

Overview:
- Parametrised successor to the fixed 8-entry coefficient look-up table used by the series-expansion datapath.
- Table is writable at runtime, is reloaded with default coefficients on reset, and has a registered random-read port.
- A built-in sequencer streams entries 0..n_terms-1 to the multiply-accumulate stage over a valid/ready handshake, so the datapath controller no longer drives table addresses.

Parameters:
- DATA_W, 16, coefficient width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  table write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- rd_addr  in  ADDR_W  random-read address.
- rd_data  out  DATA_W  registered read data, 1-cycle latency.
- start  in  1  begin a stream; sampled only in IDLE.
- n_terms  in  ADDR_W+1  number of entries to stream; captured with start.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  streamed coefficient.
- out_index  out  ADDR_W  table index of out_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset (clk edge with rst=1): state IDLE. out_valid, done, busy, out_data, out_index and rd_data are all 0.
- Reset also loads the default table. Entries 0..7 = 0x0080, 0x0015, 0x0008, 0x0004, 0x0002, 0x0001, 0x0001, 0x0001, zero-extended or truncated to DATA_W. Entries >= 8 = 0.
- Reset has priority over everything, including a stream in progress and a concurrent write.
- Write: when wr_en is high, the entry updates at the clk edge. Writes are legal in every state.
- Read: rd_data(t+1) = table[rd_addr(t)]. A read and a write to the same address in the same cycle returns the OLD value.
- FSM states: IDLE, LOAD, STREAM, FINISH.
  - IDLE: on start, capture cnt = min(n_terms, DEPTH) and set idx = 0.
    - If cnt == 0, go to FINISH; nothing is streamed.
    - Otherwise go to LOAD.
  - LOAD (1 cycle): register out_data = table[0], out_index = 0, out_valid = 1; go to STREAM. First beat is therefore valid 2 cycles after start.
  - STREAM: a beat is accepted when out_valid && out_ready.
    - Accepted and more entries remain: the next entry appears the following cycle with no bubble (idx+1).
    - Accepted and it was beat cnt-1: out_valid = 0 next cycle; go to FINISH.
    - Not accepted: out_data and out_index hold stable. A write to the displayed entry does not change the held out_data.
    - A write to a not-yet-presented entry is seen when that entry is fetched. The fetch uses the table value before any same-cycle write.
  - FINISH (1 cycle): done = 1, busy = 1; go to IDLE.
- start is ignored outside IDLE. n_terms is ignored except when start is accepted.
- Index wrap: the sequencer never wraps. Streaming stops at cnt even when cnt == DEPTH.
- Mid-stream rst: abort immediately, no done pulse, outputs cleared, table restored to defaults.

Decomposition:
- Shared package coeff_pkg holds:
  - the FSM state encoding (IDLE, LOAD, STREAM, FINISH);
  - the default-coefficient constant array (8 x 16-bit values above);
  - the DEFAULT_COUNT = 8 constant.
- One natural sub-module: coeff_regfile. It is the DEPTH x DATA_W register array with reset-to-defaults, the write port, the registered read port, and a combinational fetch port for the sequencer.
- The FSM and counter stay in the top level.

Test Plan:
- Reset, then read addresses 0..8 -> rd_data one cycle later = 0x0080, 0x0015, 0x0008, 0x0004, 0x0002, 0x0001, 0x0001, 0x0001, 0x0000.
- start with n_terms = 5, out_ready held 1 -> out_valid 2 cycles after start. Back-to-back beats 0x0080, 0x0015, 0x0008, 0x0004, 0x0002 with out_index 0..4. done pulses one cycle after the last beat; busy falls the cycle after that.
- Backpressure: n_terms = 3, out_ready = 0 for 4 cycles on beat 1 while writing 0x1234 to address 1 and 0x00AA to address 2 -> beat 1 holds 0x0015 throughout; beat 2 = 0x00AA; done occurs once.
- n_terms = 0 -> no out_valid, done 1 cycle after start. n_terms = 31 -> exactly 16 beats, indices 0..15, then done.
- start pulsed during STREAM and during FINISH -> ignored, beat count unchanged. Same-address read/write: write 0xBEEF to address 3 while reading address 3 -> rd_data = 0x0004, next read = 0xBEEF.
- rst asserted on beat 2 of a 5-term stream after writing address 0 -> next cycle out_valid = 0, busy = 0, no done pulse, and address 0 reads back 0x0080.

Source files
------------

// File: rtl/coeff_pkg.sv
// coeff_pkg: shared FSM encoding and default coefficient table for coeff_lut_stream
package coeff_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;
  localparam int DEFAULT_COUNT = 8;
  localparam logic [15:0] DEFAULT_COEFFS [DEFAULT_COUNT] = '{
    16'h0080, 16'h0015, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0001
  };
  function automatic logic [15:0] default_coeff(input int i);
    return (i < DEFAULT_COUNT) ? DEFAULT_COEFFS[i[2:0]] : 16'h0000;
  endfunction
endpackage

// File: rtl/coeff_regfile.sv
// coeff_regfile: coefficient array with reset-to-defaults, write port, registered read and combinational fetch
module coeff_regfile
  import coeff_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_W'(default_coeff(i));
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end
  assign fetch_data = mem[fetch_addr];
endmodule

// File: rtl/coeff_lut_stream.sv
// coeff_lut_stream: writable coefficient table that streams entries 0..n_terms-1 over valid/ready
module coeff_lut_stream
  import coeff_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              start,
  input  logic [ADDR_W:0]   n_terms,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              busy,
  output logic              done
);
  localparam int DEPTH = 1 << ADDR_W;
  state_t state, state_n;
  logic [ADDR_W:0] cnt, cnt_n;
  logic [ADDR_W-1:0] idx_n, fetch_addr;
  logic [DATA_W-1:0] data_n, fetch_data;
  logic valid_n, last;
  coeff_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_regfile (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .fetch_addr(fetch_addr), .fetch_data(fetch_data)
  );
  assign last = ({1'b0, out_index} + (ADDR_W+1)'(1)) == cnt;
  assign fetch_addr = (state == LOAD) ? '0 : out_index + ADDR_W'(1);
  assign busy = state != IDLE;
  assign done = state == FINISH;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    idx_n = out_index;
    data_n = out_data;
    valid_n = out_valid;
    case (state)
      IDLE: if (start) begin
        cnt_n = (n_terms > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : n_terms;
        idx_n = '0;
        state_n = (n_terms == '0) ? FINISH : LOAD;
      end
      LOAD: begin
        data_n = fetch_data;
        idx_n = '0;
        valid_n = 1'b1;
        state_n = STREAM;
      end
      STREAM: if (out_ready) begin
        valid_n = !last;
        state_n = last ? FINISH : STREAM;
        idx_n = last ? out_index : fetch_addr;
        data_n = last ? out_data : fetch_data;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      out_index <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      out_index <= idx_n;
      out_data <= data_n;
      out_valid <= valid_n;
    end
  end
endmodule

// File: tb/tb_coeff_lut_stream.sv
// tb_coeff_lut_stream: directed table-driven checks of the coefficient table and its stream sequencer
module tb_coeff_lut_stream;
  logic clk = 1'b0;
  logic rst, wr_en, start, out_valid, out_ready, busy, done;
  logic [3:0] wr_addr, rd_addr, out_index;
  logic [15:0] wr_data, rd_data, out_data;
  logic [4:0] n_terms;
  int checks = 0;
  int fails = 0;
  logic [15:0] model [16];
  typedef struct { logic [3:0] addr; logic [15:0] exp; } rd_vec_t;
  rd_vec_t rv [9];
  logic [15:0] s5_exp [5];

  coeff_lut_stream dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .start(start), .n_terms(n_terms),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    logic [15:0] d [8];
    d = '{16'h0080, 16'h0015, 16'h0008, 16'h0004, 16'h0002, 16'h0001, 16'h0001, 16'h0001};
    for (int i = 0; i < 16; i++) model[i] = (i < 8) ? d[i] : 16'h0000;
  endtask

  task automatic run_stream(input int n, input bit poke, output int beats);
    bit got_done;
    beats = 0;
    got_done = 0;
    out_ready = 1'b1;
    n_terms = 5'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && !got_done; c++) begin
      if (out_valid && out_ready) begin
        chk("stream_data", 32'(out_data), 32'(model[beats[3:0]]));
        chk("stream_index", 32'(out_index), beats);
        beats++;
      end
      got_done = done;
      start = poke && (beats == 3 || got_done);
      if (!got_done) tick();
    end
    chk("stream_done_seen", 32'(got_done), 1);
  endtask

  initial begin
    int beats;
    rv = '{'{4'd0, 16'h0080}, '{4'd1, 16'h0015}, '{4'd2, 16'h0008}, '{4'd3, 16'h0004},
           '{4'd4, 16'h0002}, '{4'd5, 16'h0001}, '{4'd6, 16'h0001}, '{4'd7, 16'h0001},
           '{4'd8, 16'h0000}};
    s5_exp = '{16'h0080, 16'h0015, 16'h0008, 16'h0004, 16'h0002};
    reset_model();
    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0; rd_addr = 0;
    start = 0; n_terms = 0; out_ready = 0;
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_index", 32'(out_index), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      rd_addr = rv[i].addr;
      tick();
      chk("default_read", 32'(rd_data), 32'(rv[i].exp));
    end

    out_ready = 1'b1;
    n_terms = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("s5_load_valid", 32'(out_valid), 0);
    chk("s5_load_busy", 32'(busy), 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s5_valid", 32'(out_valid), 1);
      chk("s5_data", 32'(out_data), 32'(s5_exp[k]));
      chk("s5_index", 32'(out_index), k);
    end
    tick();
    chk("s5_fin_valid", 32'(out_valid), 0);
    chk("s5_fin_done", 32'(done), 1);
    chk("s5_fin_busy", 32'(busy), 1);
    tick();
    chk("s5_idle_done", 32'(done), 0);
    chk("s5_idle_busy", 32'(busy), 0);

    n_terms = 5'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("bp_beat0", 32'(out_data), 32'h0080);
    tick();
    chk("bp_beat1", 32'(out_data), 32'h0015);
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      wr_en = (c < 2);
      wr_addr = (c == 0) ? 4'd1 : 4'd2;
      wr_data = (c == 0) ? 16'h1234 : 16'h00AA;
      tick();
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_hold_data", 32'(out_data), 32'h0015);
      chk("bp_hold_index", 32'(out_index), 1);
    end
    wr_en = 1'b0;
    model[1] = 16'h1234;
    model[2] = 16'h00AA;
    out_ready = 1'b1;
    tick();
    chk("bp_beat2_data", 32'(out_data), 32'h00AA);
    chk("bp_beat2_index", 32'(out_index), 2);
    tick();
    chk("bp_fin_valid", 32'(out_valid), 0);
    chk("bp_fin_done", 32'(done), 1);
    tick();
    chk("bp_done_once", 32'(done), 0);
    rd_addr = 4'd1;
    tick();
    chk("bp_rd_addr1", 32'(rd_data), 32'h1234);

    n_terms = 5'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("n0_valid", 32'(out_valid), 0);
    chk("n0_done", 32'(done), 1);
    tick();
    chk("n0_done_clear", 32'(done), 0);
    chk("n0_busy", 32'(busy), 0);

    run_stream(31, 0, beats);
    chk("n31_beats", beats, 16);
    tick();
    chk("n31_idle", 32'(busy), 0);

    run_stream(5, 1, beats);
    chk("poke_beats", beats, 5);
    tick();
    start = 1'b0;
    chk("poke_finish_ignored", 32'(busy), 0);
    tick();
    chk("poke_still_idle", 32'(busy), 0);

    rd_addr = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    chk("rw_same_old", 32'(rd_data), 32'h0004);
    tick();
    chk("rw_same_new", 32'(rd_data), 32'hBEEF);

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h5555;
    tick();
    wr_en = 1'b0;
    n_terms = 5'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("rs_beat0", 32'(out_data), 32'h5555);
    tick();
    tick();
    chk("rs_beat2_index", 32'(out_index), 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_valid", 32'(out_valid), 0);
    chk("rs_busy", 32'(busy), 0);
    chk("rs_done", 32'(done), 0);
    chk("rs_data", 32'(out_data), 0);
    rd_addr = 4'd0;
    tick();
    chk("rs_no_done", 32'(done), 0);
    chk("rs_default_addr0", 32'(rd_data), 32'h0080);
    rd_addr = 4'd3;
    tick();
    chk("rs_default_addr3", 32'(rd_data), 32'h0004);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
